// File: rtl/color_pkg.sv
// Shared constants and types for the color_loader frame assembler.
// Also defines the state encoding and the helper that packs a color triple.
package color_pkg;

  localparam logic [7:0] HEADER_BYTE      = 8'hC0;
  localparam int         NUM_QUAD         = 4;
  localparam int         FRAME_DATA_BYTES = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CSUM   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef logic [23:0] rgb_t;

  // The first byte of each triple lands in bits [23:16].
  function automatic rgb_t pack_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/color_loader_if.sv
// Load bus between color_loader (master) and color_processor (slave).
// The slave latches rgb0..rgb3 when color_valid is high.
interface color_loader_if;

  color_pkg::rgb_t rgb0;
  color_pkg::rgb_t rgb1;
  color_pkg::rgb_t rgb2;
  color_pkg::rgb_t rgb3;
  logic            color_valid;

  modport master (output rgb0, output rgb1, output rgb2, output rgb3, output color_valid);
  modport slave  (input  rgb0, input  rgb1, input  rgb2, input  rgb3, input  color_valid);

endinterface

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: counts enabled cycles without a clear and flags the
// cycle in which the count would reach TIMEOUT, so that edge aborts the frame.
module byte_timeout #(
  parameter int TMR_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer;

  // A clear in the same cycle beats expiry, so an on-time byte is never lost.
  assign expired = enable && !clear && (timer == LAST_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (clear || !enable || expired) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/color_loader.sv
// Assembles HEADER + 12 data bytes + XOR checksum into four 24-bit colors and
// presents them on the load bus with a one-cycle color_valid strobe.
module color_loader
  import color_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_BYTE,
  parameter int         TIMEOUT = 50000,
  parameter int         TMR_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid,
  color_loader_if.master load,
  output logic           busy,
  output logic           frame_err
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_DATA_BYTES - 1);

  state_t     state, state_next;
  logic [7:0] shadow [FRAME_DATA_BYTES];
  logic [3:0] count;
  logic [7:0] csum;
  rgb_t       rgb_q [NUM_QUAD];
  logic       color_valid_q;
  logic       frame_err_q;

  logic       expired;
  logic       in_frame;
  logic       commit_now;
  logic       err_now;

  assign in_frame = (state == DATA) || (state == CSUM);

  byte_timeout #(
    .TMR_W   (TMR_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (byte_valid),
    .enable  (in_frame),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    commit_now = 1'b0;
    err_now    = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid && (byte_in == HEADER)) state_next = DATA;
      end
      DATA: begin
        if (byte_valid) begin
          if (count == LAST_IDX) state_next = CSUM;
        end else if (expired) begin
          state_next = IDLE;
          err_now    = 1'b1;
        end
      end
      CSUM: begin
        if (byte_valid) begin
          if (byte_in == csum) begin
            state_next = COMMIT;
            commit_now = 1'b1;
          end else begin
            state_next = IDLE;
            err_now    = 1'b1;
          end
        end else if (expired) begin
          state_next = IDLE;
          err_now    = 1'b1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: the shadow buffer is small and must read as zero after reset, so it
  // is reset explicitly rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FRAME_DATA_BYTES; i++) shadow[i] <= '0;
      count <= '0;
      csum  <= '0;
    end else if (state == IDLE) begin
      if (byte_valid && (byte_in == HEADER)) begin
        count <= '0;
        csum  <= '0;
      end
    end else if ((state == DATA) && byte_valid) begin
      shadow[count] <= byte_in;
      csum          <= csum ^ byte_in;
      count         <= count + 1'b1;
    end
  end

  // Committed colors only move on a verified frame; everything else holds them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NUM_QUAD; q++) rgb_q[q] <= '0;
      color_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      color_valid_q <= commit_now;
      frame_err_q   <= err_now;
      if (commit_now) begin
        for (int q = 0; q < NUM_QUAD; q++) begin
          rgb_q[q] <= pack_rgb(shadow[3*q], shadow[3*q+1], shadow[3*q+2]);
        end
      end
    end
  end

  assign load.rgb0        = rgb_q[0];
  assign load.rgb1        = rgb_q[1];
  assign load.rgb2        = rgb_q[2];
  assign load.rgb3        = rgb_q[3];
  assign load.color_valid = color_valid_q;
  assign frame_err        = frame_err_q;
  assign busy             = (state != IDLE);

endmodule
